// File: rtl/std_mult_seq.sv
// std_mult_seq: sequential shift-and-add unsigned multiplier.
// Consumes one multiplier bit per clock, LSB first, and produces the full
// 2*width product as {out_hi, out}. done pulses for one cycle per result.
// Optional feature macro: STD_MULT_SEQ_ZERO_SKIP_EN. When it is defined, a
// zero operand finishes in a single edge instead of width+1 edges.
module std_mult_seq #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             go,
    input  logic [width-1:0] left,
    input  logic [width-1:0] right,
    output logic [width-1:0] out,
    output logic [width-1:0] out_hi,
    output logic             done
);

    localparam int CW = (width > 2) ? $clog2(width) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(width - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [width-1:0]   mcand;
    logic [width-1:0]   mplier;
    logic [2*width-1:0] acc;
    logic [CW-1:0]      cnt;

    logic [width:0]     sum;
    logic [2*width-1:0] acc_next;

    // One shift-and-add step: add the multiplicand into the upper half when
    // the current multiplier bit is set, keeping the carry, then shift right.
    always_comb begin
        sum      = {1'b0, acc[2*width-1:width]} + {1'b0, (mplier[0] ? mcand : {width{1'b0}})};
        acc_next = {sum, acc[width-1:1]};
    end

    // Control FSM with registered result and done outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            out    <= '0;
            out_hi <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
`ifdef STD_MULT_SEQ_ZERO_SKIP_EN
                        if (left == '0 || right == '0) begin
                            // Product is trivially zero: report it right away.
                            out    <= '0;
                            out_hi <= '0;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else
`endif
                        begin
                            mcand  <= left;
                            mplier <= right;
                            acc    <= '0;
                            cnt    <= '0;
                            state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (!go) begin
                        // Caller withdrew the request: abandon, keep old result.
                        state <= IDLE;
                    end else begin
                        acc    <= acc_next;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 1'b1;
                        if (cnt == LAST_BIT) begin
                            // Final bit consumed this cycle: publish the product.
                            out    <= acc_next[width-1:0];
                            out_hi <= acc_next[2*width-1:width];
                            done   <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_std_mult_seq.sv
// Self-checking bench for std_mult_seq (width = 32), scoreboard based.
module tb_std_mult_seq;

    localparam int W = 32;

    logic         clk;
    logic         reset_n;
    logic         go;
    logic [W-1:0] left;
    logic [W-1:0] right;
    logic [W-1:0] out;
    logic [W-1:0] out_hi;
    logic         done;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int go_edge = 0;
    logic [2*W-1:0] sb[$];
    logic [2*W-1:0] last_res = '0;

    std_mult_seq #(.width(W)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .go(go),
        .left(left),
        .right(right),
        .out(out),
        .out_hi(out_hi),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic int exp_lat(input logic [W-1:0] l, input logic [W-1:0] r);
`ifdef STD_MULT_SEQ_ZERO_SKIP_EN
        if (l == '0 || r == '0) return 1;
`endif
        return W + 1;
    endfunction

    // Drive a request at a negedge and record the expected product.
    task automatic start_op(input logic [W-1:0] l, input logic [W-1:0] r);
        logic [2*W-1:0] p;
        left  = l;
        right = r;
        go    = 1'b1;
        go_edge = edge_cnt;
        p = {{W{1'b0}}, l} * {{W{1'b0}}, r};
        sb.push_back(p);
        $display("start %0h * %0h expect %016h", l, r, p);
    endtask

    // Wait for done, check latency in edges and the product against the scoreboard.
    task automatic wait_result(input int lat, input string name);
        bit seen;
        logic [2*W-1:0] exp;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        exp = sb.pop_front();
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: done never rose, required within %0d edges", name, lat);
        end else if (edge_cnt - go_edge != lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d edges, required %0d", name, edge_cnt - go_edge, lat);
        end
        checks++;
        if ({out_hi, out} !== exp) begin
            errors++;
            $display("FAIL %s_result: got %016h, required %016h", name, {out_hi, out}, exp);
        end else begin
            $display("result %s = %016h at latency %0d", name, {out_hi, out}, edge_cnt - go_edge);
        end
        last_res = exp;
    endtask

    // Release go after done and confirm done is a single-cycle pulse.
    task automatic finish_op(input string name);
        go = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse: done=%b one cycle later, required 0", name, done);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        go = 1'b0;
        left = '0;
        right = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b0 || out !== '0 || out_hi !== '0) begin
            errors++;
            $display("FAIL reset_state: done=%b out=%h out_hi=%h, required 0/0/0", done, out, out_hi);
        end
        reset_n = 1'b1;
        @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_basic();
        start_op(32'd3, 32'd5);
        wait_result(W + 1, "mul_3x5");
        finish_op("mul_3x5");
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result(W + 1, "mul_max");
        finish_op("mul_max");
    endtask

    task automatic test_abort();
        // Make previous result 15/0 so the hold check is meaningful.
        start_op(32'd3, 32'd5);
        wait_result(W + 1, "pre_abort");
        finish_op("pre_abort");
        left = 32'd7;
        right = 32'd9;
        go = 1'b1;
        repeat (11) @(negedge clk);
        go = 1'b0;
        begin
            bit pulsed;
            pulsed = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done) pulsed = 1;
            end
            checks++;
            if (pulsed) begin
                errors++;
                $display("FAIL abort_no_done: done pulsed after abort, required none");
            end
        end
        checks++;
        if ({out_hi, out} !== last_res) begin
            errors++;
            $display("FAIL abort_hold: got %016h, required %016h", {out_hi, out}, last_res);
        end
        $display("abort 7*9 held %016h", {out_hi, out});
        start_op(32'd2, 32'd2);
        wait_result(W + 1, "after_abort_2x2");
        finish_op("after_abort_2x2");
    endtask

    task automatic test_reset_mid();
        left = 32'h0001_0000;
        right = 32'h0001_0000;
        go = 1'b1;
        repeat (6) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (done !== 1'b0 || out !== '0 || out_hi !== '0) begin
            errors++;
            $display("FAIL async_reset: done=%b out=%h out_hi=%h, required 0/0/0 without edge", done, out, out_hi);
        end
        $display("async reset mid-run out=%h out_hi=%h", out, out_hi);
        go = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        start_op(32'd6, 32'd7);
        wait_result(W + 1, "after_reset_6x7");
        finish_op("after_reset_6x7");
    endtask

    task automatic test_back_to_back();
        start_op(32'd100, 32'd200);
        wait_result(W + 1, "b2b_first");
        // go stays high; new operands are sampled after DONE returns to IDLE.
        start_op(32'h8000_0000, 32'd2);
        wait_result(W + 2, "b2b_second");
        finish_op("b2b_second");
    endtask

    task automatic test_operand_change();
        for (int k = 0; k < 4; k++) begin
            logic [W-1:0] a, b;
            a = $urandom;
            b = $urandom;
            start_op(a, b);
            fork
                begin
                    repeat (4) @(negedge clk);
                    left = $urandom;
                    right = $urandom;
                end
            join_none
            wait_result(exp_lat(a, b), "latched_operands");
            finish_op("latched_operands");
        end
    endtask

    task automatic test_zero();
        start_op(32'd0, 32'd123);
        wait_result(exp_lat(32'd0, 32'd123), "zero_left");
        finish_op("zero_left");
        start_op(32'd77, 32'd0);
        wait_result(exp_lat(32'd77, 32'd0), "zero_right");
        finish_op("zero_right");
    endtask

    initial begin
        reset_n = 1'b0;
        go = 1'b0;
        left = '0;
        right = '0;
        test_reset();
        test_basic();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        test_operand_change();
        test_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
